// File: rtl/instr_mem.sv
// instr_mem: fetch-port word memory loaded from a little-endian byte-stream image
// (4-byte word count, then the words themselves). Read port is registered and read-first.
module instr_mem #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       rom_addr,
   output logic [31:0]       rom_data,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   input  logic              reload,
   output logic              loaded,
   output logic              overflow,
   output logic [ADDR_W:0]   words_loaded
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic [1:0] {HDR, DATA, DONE} state_t;
   state_t            r_state, w_next;
   logic [1:0]        r_cnt;
   logic [23:0]       r_shift;
   logic [31:0]       r_count, r_wptr, r_rom_data;
   logic              r_loaded, r_overflow;
   logic [ADDR_W:0]   r_words;
   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       w_word;
   logic              w_take, w_hdr_end, w_word_end, w_last_word;
   logic              w_wr, w_ovf_set, w_done_set, w_reload, w_unused;

   assign w_word      = {load_byte, r_shift};
   assign w_take      = load_valid && r_state != DONE;
   assign w_hdr_end   = w_take && r_cnt == 2'd3 && r_state == HDR;
   assign w_word_end  = w_take && r_cnt == 2'd3 && r_state == DATA;
   assign w_last_word = r_wptr == r_count - 32'd1;
   assign w_unused    = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_state <= HDR;
      else       r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (w_hdr_end) w_next = (w_word == '0) ? DONE : DATA;
      if (w_word_end && w_last_word) w_next = DONE;
      if (r_state == DONE && reload) w_next = HDR;
   end

   always_comb begin
      w_wr       = w_word_end && r_wptr < 32'(DEPTH);
      w_ovf_set  = w_word_end && !(r_wptr < 32'(DEPTH));
      w_done_set = w_next == DONE && r_state != DONE;
      w_reload   = r_state == DONE && reload;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_loaded   <= 1'b0;
         r_overflow <= 1'b0;
         r_words    <= '0;
         r_rom_data <= '0;
      end else begin
         r_rom_data <= r_mem[rom_addr[ADDR_W+1:2]];
         if (w_take) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {load_byte, r_shift[23:8]};
         end
         if (w_reload) r_cnt <= '0;
         if (w_hdr_end) begin
            r_count <= w_word;
            r_wptr  <= '0;
         end
         if (w_word_end) r_wptr <= r_wptr + 32'd1;
         if (w_reload)        r_loaded <= 1'b0;
         else if (w_done_set) r_loaded <= 1'b1;
         if (w_reload)       r_overflow <= 1'b0;
         else if (w_ovf_set) r_overflow <= 1'b1;
         if (w_reload)  r_words <= '0;
         else if (w_wr) r_words <= r_words + (ADDR_W+1)'(1);
      end

   // Memory is deliberately outside reset so an image survives core resets.
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wptr[ADDR_W-1:0]] <= w_word;

   assign rom_data     = r_rom_data;
   assign loaded       = r_loaded;
   assign overflow     = r_overflow;
   assign words_loaded = r_words;
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed image loads into a 4-word instance with queued and direct checks
module tb_instr_mem;
  localparam int AW = 2;
  logic clk, rstn, load_valid, reload;
  logic [31:0] rom_addr, rom_data;
  logic [7:0] load_byte;
  logic loaded, overflow;
  logic [AW:0] words_loaded;
  int n_chk = 0, n_fail = 0;
  typedef struct {string name; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];
  instr_mem #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rom_addr(rom_addr), .rom_data(rom_data),
    .load_valid(load_valid), .load_byte(load_byte), .reload(reload),
    .loaded(loaded), .overflow(overflow), .words_loaded(words_loaded)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] act(int sel);
    return sel == 0 ? rom_data : sel == 1 ? {31'b0, loaded} :
           sel == 2 ? {31'b0, overflow} : 32'(words_loaded);
  endfunction
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = act(e.sel);
      n_chk++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
      end
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_rst(string n);
    chk({n, ".rom_data"}, rom_data, 32'h0);
    chk({n, ".loaded"}, {31'b0, loaded}, 32'h0);
    chk({n, ".overflow"}, {31'b0, overflow}, 32'h0);
    chk({n, ".words_loaded"}, 32'(words_loaded), 32'h0);
  endtask
  task automatic expect_v(string n, int sel, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask
  task automatic expect_st(string n, logic ld, logic ov, int wl);
    expect_v({n, ".loaded"}, 1, {31'b0, ld});
    expect_v({n, ".overflow"}, 2, {31'b0, ov});
    expect_v({n, ".words_loaded"}, 3, 32'(wl));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_loaded(string n, int max);
    int i = 0;
    while (!loaded && i < max) begin
      tick();
      i++;
    end
    n_chk++;
    if (!loaded) begin
      n_fail++;
      $display("FAIL %s: loaded not seen within %0d cycles at %0t", n, max, $time);
    end
  endtask
  task automatic send(logic [7:0] b, int gap);
    load_valid = 1'b1;
    load_byte = b;
    tick();
    load_valid = 1'b0;
    repeat (gap) tick();
  endtask
  task automatic send_word(logic [31:0] w, int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap > 0 ? int'($urandom_range(0, gap)) : 0);
  endtask
  task automatic read(logic [31:0] a, logic [31:0] v, string n);
    rom_addr = a;
    tick();
    expect_v(n, 0, v);
  endtask
  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask
  initial begin
    rstn = 1'b1; load_valid = 1'b0; load_byte = '0; reload = 1'b0; rom_addr = '0;
    #2 rstn = 1'b0;
    #1;
    chk_rst("reset");
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    send_word(32'd2, 0);
    send_word(32'hDEADBEEF, 0);
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0);
    expect_v("basic.loaded_early", 1, 32'h0);
    send(8'h12, 0);
    expect_st("basic.done", 1'b1, 1'b0, 2);
    read(32'h0, 32'hDEADBEEF, "basic.rd0");
    read(32'h4, 32'h12345678, "basic.rd4");
    read(32'h7, 32'h12345678, "basic.rd7");
    read(32'h0, 32'hDEADBEEF, "basic.rd0b");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_rst("async_rst");
    tick();
    rstn = 1'b1;
    send_word(32'd2, 5);
    send_word(32'hDEADBEEF, 5);
    send(8'h78, 3); send(8'h56, 3); send(8'h34, 3);
    expect_v("gap.loaded_early", 1, 32'h0);
    send(8'h12, 0);
    wait_loaded("gap.wait", 4);
    expect_st("gap.done", 1'b1, 1'b0, 2);
    read(32'h0, 32'hDEADBEEF, "gap.rd0");
    read(32'h4, 32'h12345678, "gap.rd4");
    do_reload();
    expect_st("empty.reload", 1'b0, 1'b0, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    expect_v("empty.loaded_early", 1, 32'h0);
    send(8'h00, 0);
    expect_st("empty.done", 1'b1, 1'b0, 0);
    do_reload();
    send_word(32'd6, 0);
    for (int i = 0; i < 6; i++) begin
      send_word(32'h11111111 * (i + 1), 0);
      if (i == 3) expect_st("ovf.w3", 1'b0, 1'b0, 4);
      if (i == 4) expect_st("ovf.w4", 1'b0, 1'b1, 4);
    end
    expect_st("ovf.done", 1'b1, 1'b1, 4);
    read(32'h0, 32'h11111111, "ovf.rd0");
    read(32'h4, 32'h22222222, "ovf.rd4");
    read(32'h8, 32'h33333333, "ovf.rd8");
    read(32'hC, 32'h44444444, "ovf.rdC");
    read(32'h10, 32'h11111111, "ovf.alias10");
    do_reload();
    expect_st("midrst.reload", 1'b0, 1'b0, 0);
    send_word(32'd1, 0);
    send(8'h55, 0); send(8'h66, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    send_word(32'd1, 0);
    send_word(32'h44332211, 0);
    wait_loaded("midrst.wait", 4);
    expect_st("midrst.done", 1'b1, 1'b0, 1);
    read(32'h0, 32'h44332211, "midrst.rd0");
    send_word(32'd1, 0);
    send_word(32'h99999999, 0);
    expect_st("done_drop", 1'b1, 1'b0, 1);
    read(32'h0, 32'h44332211, "done_drop.rd0");
    do_reload();
    expect_st("rf.reload", 1'b0, 1'b0, 0);
    send_word(32'd1, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    send(8'hDD, 0);
    expect_v("rf.old_word", 0, 32'h44332211);
    expect_st("rf.done", 1'b1, 1'b0, 1);
    tick();
    expect_v("rf.new_word", 0, 32'hDDCCBBAA);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
